apb_interconnect: RTL and testbench
===================================

Name: apb_interconnect

Overview:
Parametrised APB bridge fabric: one requester port fanned out to NUM_SLAVES completers through slot-based address decode. Generalises the fixed two-slave decoder with the following additions:
- N completer ports.
- PSLVERR generation for unmapped slots.
- Per-transfer wait-state timeout.
- Protocol-phase tracking with sticky violation flag.
- Saturating error counter with last-error address capture.

Sits between the APB master and the peripheral completers in the APB subsystem top.

Parameters:
NUM_SLAVES, 4, number of completer ports (1..16)
ADDR_W, 32, requester address width
DATA_W, 32, data width
SLOT_LSB, 4, lowest address bit of slot index
SEL_W, 4, slot index width; slot = PADDR[SLOT_LSB+SEL_W-1:SLOT_LSB]
TIMEOUT, 16, max wait cycles in access phase before forced error; 0 disables

Ports:
PCLK  in  1  clock
PRESET  in  1  asynchronous active-high reset
PADDR  in  ADDR_W  requester address
PWDATA  in  DATA_W  write data
PWRITE  in  1  write strobe
PSEL  in  1  requester select
PENABLE  in  1  access phase
PRDATA  out  DATA_W  read data to requester
PREADY  out  1  ready to requester
PSLVERR  out  1  error to requester
s_PSEL  out  NUM_SLAVES  one-hot completer selects
s_PADDR  out  SLOT_LSB+SEL_W  PADDR[SLOT_LSB+SEL_W-1:0], broadcast
s_PWDATA  out  DATA_W  broadcast PWDATA
s_PWRITE  out  1  broadcast PWRITE
s_PENABLE  out  1  broadcast PENABLE
s_PRDATA  in  NUM_SLAVES*DATA_W  packed; slave i at [i*DATA_W +: DATA_W]
s_PREADY  in  NUM_SLAVES  completer ready
s_PSLVERR  in  NUM_SLAVES  completer error
err_clr  in  1  synchronous clear of err_count, last_err_addr, proto_err
err_count  out  16  saturating count of error-terminated transfers
last_err_addr  out  ADDR_W  PADDR of most recent error-terminated transfer
proto_err  out  1  sticky protocol violation flag

Behaviour:
- Reset (PRESET high, async):
  - FSM returns to IDLE; wait counter cleared.
  - err_count=0, last_err_addr=0, proto_err=0.
  - Combinational outputs follow their rules below. With PSEL low: PREADY=1, PSLVERR=0, PRDATA=0, s_PSEL=0.
- Decode (combinational):
  - slot = PADDR slot field.
  - mapped when slot < NUM_SLAVES. s_PSEL[slot] = PSEL & mapped; all other bits 0.
- Response mux (combinational):
  - Mapped: PRDATA/PREADY/PSLVERR from completer[slot], unless the timeout override is active.
  - Unmapped with PSEL high: PREADY=1, PRDATA=0, PSLVERR = PENABLE (zero-wait error).
  - PSEL low: PREADY=1, PRDATA=0, PSLVERR=0.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP on PSEL & !PENABLE.
  - SETUP -> ACCESS unconditionally next cycle.
  - ACCESS stays while PREADY (to requester) low.
  - ACCESS on PREADY high -> SETUP if PSEL & !PENABLE next, else IDLE (standard back-to-back rule applies).
- Protocol violations set proto_err (sticky) on the offending edge:
  - PENABLE high in IDLE.
  - PENABLE low while in SETUP-expected access, i.e. PSEL & !PENABLE observed in ACCESS before completion.
  - PADDR/PWRITE/PWDATA changing between SETUP and ACCESS, or within ACCESS.
  - Violations do not alter routing.
- Timeout (TIMEOUT>0):
  - Wait counter clears on entry to ACCESS and increments each ACCESS cycle with completer PREADY low.
  - When counter == TIMEOUT and completer PREADY still low: that cycle PREADY=1, PSLVERR=1, PRDATA=0 to requester (override).
  - s_PSEL drops on the following cycle per requester.
  - A completer PREADY rising in the same cycle as the timeout wins: normal completion, no error.
- Error accounting, on every completed access with PSLVERR=1 (completer, unmapped or timeout):
  - err_count += 1, saturating at 16'hFFFF.
  - last_err_addr <= PADDR.
- err_clr:
  - Clears err_count, last_err_addr and proto_err.
  - If an error completes in the same cycle, clear wins and the event is dropped.
- Reset mid-transfer aborts immediately. Slave handshake state is the slave's responsibility.

Test Plan:
- Write 0x11223344 to PADDR=0x20 (slot 2), slave ready after 2 waits -> s_PSEL=4'b0100, requester PREADY high at 3rd ACCESS cycle, PSLVERR=0, err_count=0.
- Read PADDR=0x30, slave 3 returns 0xCAFEF00D zero-wait -> PRDATA=0xCAFEF00D in the ACCESS cycle; back-to-back read of 0x00 reaches SETUP without an IDLE cycle.
- Access PADDR=0x50 (unmapped, NUM_SLAVES=4) -> s_PSEL=0, PREADY=1 and PSLVERR=1 in ACCESS, err_count=1, last_err_addr=0x50.
- Slave 1 holds PREADY low forever, TIMEOUT=16 -> forced PREADY=1, PSLVERR=1 on ACCESS cycle 17, err_count increments; repeat with slave ready exactly on that cycle -> no error.
- PENABLE asserted with no SETUP, then PADDR changed mid-ACCESS -> proto_err=1 and stays set; err_clr pulse -> proto_err=0, err_count=0.
- 65536 unmapped accesses -> err_count saturates at 0xFFFF; PRESET asserted during ACCESS -> all status outputs 0 asynchronously, FSM in IDLE.

Source files
------------

// File: rtl/apb_interconnect_if.sv
// APB requester bus plus fanned-out completer buses for apb_interconnect.
// master: environment (requester and completers); slave: the fabric.
interface apb_interconnect_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SLOT_LSB   = 4,
  parameter int SEL_W      = 4
);
  localparam int SA_W = SLOT_LSB + SEL_W;

  logic [ADDR_W-1:0]            PADDR;
  logic [DATA_W-1:0]            PWDATA;
  logic                         PWRITE;
  logic                         PSEL;
  logic                         PENABLE;
  logic [DATA_W-1:0]            PRDATA;
  logic                         PREADY;
  logic                         PSLVERR;

  logic [NUM_SLAVES-1:0]        s_PSEL;
  logic [SA_W-1:0]              s_PADDR;
  logic [DATA_W-1:0]            s_PWDATA;
  logic                         s_PWRITE;
  logic                         s_PENABLE;
  logic [NUM_SLAVES*DATA_W-1:0] s_PRDATA;
  logic [NUM_SLAVES-1:0]        s_PREADY;
  logic [NUM_SLAVES-1:0]        s_PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR,
    input  s_PSEL, s_PADDR, s_PWDATA, s_PWRITE, s_PENABLE,
    output s_PRDATA, s_PREADY, s_PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR,
    output s_PSEL, s_PADDR, s_PWDATA, s_PWRITE, s_PENABLE,
    input  s_PRDATA, s_PREADY, s_PSLVERR
  );
endinterface

// File: rtl/apb_interconnect.sv
// APB 1-to-N slot-decoded fabric with unmapped/timeout error response,
// protocol-phase checking and error accounting.
module apb_interconnect #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SLOT_LSB   = 4,
  parameter int SEL_W      = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_interconnect_if.slave bus,
  input  logic              err_clr,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] last_err_addr,
  output logic              proto_err
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam int          SA_W   = SLOT_LSB + SEL_W;
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  state_t                r_state, w_cur, w_nxt;
  logic [SEL_W-1:0]      w_slot;
  logic                  w_mapped;
  logic [NUM_SLAVES-1:0] w_sel;
  logic                  w_srdy, w_serr, w_to;
  logic [DATA_W-1:0]     w_srdata, w_prdata;
  logic                  w_pready, w_pslverr;
  logic                  w_done, w_chg, w_viol;
  logic [15:0]           r_wcnt, r_cnt;
  logic [ADDR_W-1:0]     r_addr, r_last;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_write, r_proto;

  assign w_slot   = bus.PADDR[SLOT_LSB +: SEL_W];
  assign w_mapped = 32'(w_slot) < NUM_SLAVES;

  always_comb begin
    w_sel    = '0;
    w_srdy   = 1'b1;
    w_serr   = 1'b0;
    w_srdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (w_slot == SEL_W'(i)) begin
        w_sel[i] = bus.PSEL;
        w_srdy   = bus.s_PREADY[i];
        w_serr   = bus.s_PSLVERR[i];
        w_srdata = bus.s_PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  // A completer ready in the timeout cycle takes priority over the override
  assign w_to = (TIMEOUT != 0) && (r_state == ACCESS) && bus.PSEL &&
                w_mapped && !w_srdy && (r_wcnt == TO_LIM);

  always_comb begin
    w_pready  = 1'b1;
    w_pslverr = 1'b0;
    w_prdata  = '0;
    if (bus.PSEL) begin
      if (!w_mapped) begin
        w_pslverr = bus.PENABLE;
      end else if (w_to) begin
        w_pslverr = 1'b1;
      end else begin
        w_pready  = w_srdy;
        w_pslverr = w_serr;
        w_prdata  = w_srdata;
      end
    end
  end

  // A setup cycle is recognised in the same cycle it appears on the bus,
  // so back-to-back transfers go ACCESS -> SETUP with no idle gap.
  always_comb begin
    w_cur = r_state;
    if (r_state == IDLE && bus.PSEL && !bus.PENABLE) w_cur = SETUP;
    w_nxt = IDLE;
    case (w_cur)
      SETUP:   w_nxt = ACCESS;
      ACCESS:  w_nxt = w_pready ? IDLE : ACCESS;
      default: w_nxt = IDLE;
    endcase
  end

  assign w_done = bus.PSEL && bus.PENABLE && w_pready;
  assign w_chg  = (bus.PADDR != r_addr) || (bus.PWRITE != r_write) ||
                  (bus.PWDATA != r_wdata);
  assign w_viol = ((w_cur == IDLE) && bus.PENABLE) ||
                  ((r_state == ACCESS) && bus.PSEL &&
                   (!bus.PENABLE || w_chg));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_cur == SETUP)
        r_wcnt <= '0;
      else if (r_state == ACCESS && !w_srdy && r_wcnt != 16'hFFFF)
        r_wcnt <= r_wcnt + 16'd1;
      if (w_cur != IDLE) begin
        r_addr  <= bus.PADDR;
        r_wdata <= bus.PWDATA;
        r_write <= bus.PWRITE;
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_cnt   <= '0;
      r_last  <= '0;
      r_proto <= 1'b0;
    end else if (err_clr) begin
      r_cnt   <= '0;
      r_last  <= '0;
      r_proto <= 1'b0;
    end else begin
      if (w_done && w_pslverr) begin
        if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
        r_last <= bus.PADDR;
      end
      if (w_viol) r_proto <= 1'b1;
    end
  end

  assign bus.PRDATA    = w_prdata;
  assign bus.PREADY    = w_pready;
  assign bus.PSLVERR   = w_pslverr;
  assign bus.s_PSEL    = w_sel;
  assign bus.s_PADDR   = bus.PADDR[SA_W-1:0];
  assign bus.s_PWDATA  = bus.PWDATA;
  assign bus.s_PWRITE  = bus.PWRITE;
  assign bus.s_PENABLE = bus.PENABLE;

  assign err_count     = r_cnt;
  assign last_err_addr = r_last;
  assign proto_err     = r_proto;
endmodule

// File: tb/tb_apb_interconnect.sv
// Bench for apb_interconnect: directed APB scenarios and randomized
// transfers checked against a transfer-level reference model.
module tb_apb_interconnect;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int SW = 4;
  localparam int TO = 16;
  localparam int PW = NS * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic [15:0]   err_count;
  logic [AW-1:0] last_err_addr;
  logic          proto_err;

  int checks   = 0;
  int failures = 0;

  logic [15:0]   m_cnt   = '0;
  logic [AW-1:0] m_last  = '0;
  logic          m_proto = 1'b0;

  apb_interconnect_if #(
    .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
    .SLOT_LSB(SL), .SEL_W(SW)
  ) bif ();

  apb_interconnect #(
    .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
    .SLOT_LSB(SL), .SEL_W(SW), .TIMEOUT(TO)
  ) dut (
    .PCLK(clk),
    .PRESET(rst),
    .bus(bif),
    .err_clr(clr),
    .err_count(err_count),
    .last_err_addr(last_err_addr),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bif.PSEL    = 1'b0;
    bif.PENABLE = 1'b0;
    cyc();
  endtask

  task automatic model_err(input logic [AW-1:0] a);
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    m_last = a;
  endtask

  task automatic model_clr();
    m_cnt   = '0;
    m_last  = '0;
    m_proto = 1'b0;
  endtask

  task automatic drive_slaves(input int slot, input logic rdy,
                              input logic err, input logic [DW-1:0] rd);
    logic [NS-1:0] r;
    logic [NS-1:0] e;
    logic [PW-1:0] d;
    r = NS'($urandom);
    e = NS'($urandom);
    d = {$urandom, $urandom, $urandom, $urandom};
    if (slot < NS) begin
      r = (r & ~(NS'(1) << slot)) | (NS'(rdy) << slot);
      e = (e & ~(NS'(1) << slot)) | (NS'(err) << slot);
      d = (d & ~(PW'({DW{1'b1}}) << (slot * DW))) |
          (PW'(rd) << (slot * DW));
    end
    bif.s_PREADY  = r;
    bif.s_PSLVERR = e;
    bif.s_PRDATA  = d;
  endtask

  // One complete APB transfer; waits > TO means the completer never answers
  task automatic xfer(input logic [AW-1:0] addr, input logic wr,
                      input logic [DW-1:0] wd, input int waits,
                      input logic err, input logic [DW-1:0] rd,
                      input logic clr_done);
    int            slot;
    int            ek;
    logic          mapped, tmo, e_err, done;
    logic [DW-1:0] e_rd;
    slot   = int'(addr[SL +: SW]);
    mapped = slot < NS;
    tmo    = mapped && (waits > TO);
    ek     = !mapped ? 0 : (tmo ? TO : waits);
    e_err  = !mapped || tmo || err;
    e_rd   = (mapped && !tmo) ? rd : '0;
    bif.PSEL    = 1'b1;
    bif.PENABLE = 1'b0;
    bif.PADDR   = addr;
    bif.PWRITE  = wr;
    bif.PWDATA  = wd;
    drive_slaves(slot, 1'b0, err, rd);
    #1;
    chk("s_psel_setup", 64'(bif.s_PSEL),
        64'(mapped ? (NS'(1) << slot) : NS'(0)));
    chk("s_paddr", 64'(bif.s_PADDR), 64'(addr[SL+SW-1:0]));
    cyc();
    bif.PENABLE = 1'b1;
    done = 1'b0;
    for (int k = 0; k <= 40 && !done; k++) begin
      drive_slaves(slot, k == waits, err, rd);
      clr = clr_done && (k == ek);
      #1;
      chk("pready", 64'(bif.PREADY), 64'(k == ek));
      if (k == 0) begin
        chk("s_penable", 64'(bif.s_PENABLE), 64'(1'b1));
        chk("s_pwrite", 64'(bif.s_PWRITE), 64'(wr));
        chk("s_pwdata", 64'(bif.s_PWDATA), 64'(wd));
      end
      if (k == ek) begin
        chk("pslverr", 64'(bif.PSLVERR), 64'(e_err));
        chk("prdata", 64'(bif.PRDATA), 64'(e_rd));
        if (clr_done) model_clr();
        else if (e_err) model_err(addr);
      end
      cyc();
      clr = 1'b0;
      if (k == ek) begin
        done = 1'b1;
        chk("err_count", 64'(err_count), 64'(m_cnt));
        chk("last_err_addr", 64'(last_err_addr), 64'(m_last));
        chk("proto_err", 64'(proto_err), 64'(m_proto));
      end
    end
    chk("xfer_done", 64'(done), 64'(1'b1));
  endtask

  initial begin
    bif.PSEL      = 1'b0;
    bif.PENABLE   = 1'b0;
    bif.PADDR     = '0;
    bif.PWDATA    = '0;
    bif.PWRITE    = 1'b0;
    bif.s_PREADY  = '0;
    bif.s_PSLVERR = '0;
    bif.s_PRDATA  = '0;
    #1 rst = 1'b1;
    #10;
    chk("rst_err_count", 64'(err_count), 64'(16'h0));
    chk("rst_last_addr", 64'(last_err_addr), 64'(32'h0));
    chk("rst_proto", 64'(proto_err), 64'(1'b0));
    chk("rst_pready", 64'(bif.PREADY), 64'(1'b1));
    chk("rst_pslverr", 64'(bif.PSLVERR), 64'(1'b0));
    chk("rst_prdata", 64'(bif.PRDATA), 64'(32'h0));
    chk("rst_s_psel", 64'(bif.s_PSEL), 64'(4'h0));
    @(negedge clk);
    rst = 1'b0;
    cyc();

    xfer(32'h20, 1'b1, 32'h11223344, 2, 1'b0, 32'h0BAD0BAD, 1'b0);
    idle();
    xfer(32'h30, 1'b0, 32'h0, 0, 1'b0, 32'hCAFEF00D, 1'b0);
    xfer(32'h00, 1'b0, 32'h0, 1, 1'b0, 32'h12345678, 1'b0);
    idle();
    xfer(32'h50, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0);
    idle();
    xfer(32'h10, 1'b0, 32'h0, 40, 1'b0, 32'h55AA55AA, 1'b0);
    idle();
    xfer(32'h10, 1'b1, 32'h600DF00D, TO, 1'b0, 32'hA5A5A5A5, 1'b0);
    idle();
    xfer(32'h64, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b1);
    idle();

    for (int t = 0; t < 60; t++) begin
      logic [AW-1:0] a;
      int            sel;
      int            w;
      a = $urandom;
      a[SL +: SW] = SW'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      w = (sel < 6) ? sel % 4 : ((sel < 8) ? TO : TO + 24);
      xfer(a, 1'($urandom), $urandom, w, 1'($urandom), $urandom, 1'b0);
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();

    xfer(32'h7C, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0);
    idle();
    bif.PSEL    = 1'b1;
    bif.PENABLE = 1'b1;
    bif.PADDR   = 32'h04;
    drive_slaves(0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("viol_route", 64'(bif.s_PSEL), 64'(4'b0001));
    cyc();
    m_proto = 1'b1;
    chk("proto_set", 64'(proto_err), 64'(m_proto));
    idle();
    chk("proto_sticky", 64'(proto_err), 64'(m_proto));
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    model_clr();
    chk("clr_proto", 64'(proto_err), 64'(m_proto));
    chk("clr_count", 64'(err_count), 64'(m_cnt));
    chk("clr_last", 64'(last_err_addr), 64'(m_last));

    bif.PSEL    = 1'b1;
    bif.PENABLE = 1'b0;
    bif.PADDR   = 32'h10;
    drive_slaves(1, 1'b0, 1'b0, 32'h0);
    cyc();
    bif.PENABLE = 1'b1;
    drive_slaves(1, 1'b0, 1'b0, 32'h0);
    cyc();
    chk("stable_no_viol", 64'(proto_err), 64'(m_proto));
    bif.PADDR = 32'h14;
    drive_slaves(1, 1'b0, 1'b0, 32'h0);
    cyc();
    m_proto = 1'b1;
    chk("addr_chg_viol", 64'(proto_err), 64'(m_proto));
    drive_slaves(1, 1'b1, 1'b0, 32'h0);
    cyc();
    idle();
    chk("addr_chg_sticky", 64'(proto_err), 64'(m_proto));
    chk("addr_chg_count", 64'(err_count), 64'(m_cnt));
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    model_clr();

    bif.PSEL    = 1'b1;
    bif.PENABLE = 1'b0;
    bif.PADDR   = 32'h70;
    cyc();
    bif.PENABLE = 1'b1;
    for (int n = 1; n <= 65537; n++) begin
      cyc();
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (n == 65534) chk("near_sat", 64'(err_count), 64'(m_cnt));
    end
    m_last  = 32'h70;
    m_proto = 1'b1;
    chk("sat_count", 64'(err_count), 64'(m_cnt));
    chk("sat_last", 64'(last_err_addr), 64'(m_last));
    chk("sat_proto", 64'(proto_err), 64'(m_proto));
    idle();

    bif.PSEL    = 1'b1;
    bif.PENABLE = 1'b0;
    bif.PADDR   = 32'h10;
    drive_slaves(1, 1'b0, 1'b0, 32'h0);
    cyc();
    bif.PENABLE = 1'b1;
    drive_slaves(1, 1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    model_clr();
    #1;
    chk("arst_count", 64'(err_count), 64'(m_cnt));
    chk("arst_last", 64'(last_err_addr), 64'(m_last));
    chk("arst_proto", 64'(proto_err), 64'(m_proto));
    bif.PSEL    = 1'b0;
    bif.PENABLE = 1'b0;
    #1;
    chk("arst_pready", 64'(bif.PREADY), 64'(1'b1));
    chk("arst_pslverr", 64'(bif.PSLVERR), 64'(1'b0));
    chk("arst_prdata", 64'(bif.PRDATA), 64'(32'h0));
    chk("arst_s_psel", 64'(bif.s_PSEL), 64'(4'h0));
    @(negedge clk);
    rst = 1'b0;
    cyc();
    xfer(32'h20, 1'b0, 32'h0, 1, 1'b0, 32'hFEEDBEEF, 1'b0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
